// File: rtl/idct_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// idct_pkg : shared widths, cosine table and output rounding for idct_1d
// Rev 1.0
// ------------------------------------------------------------------
package idct_pkg;

  localparam int W_IN_DEF       = 15;
  localparam int W_OUT_DEF      = 12;
  localparam int CONST_PREC_DEF = 14;
  localparam int GUARD_DEF      = 3;

  typedef logic [2:0] slot_t;

  // Upper half of a block computes odd-index (O) terms, lower half even-index (E) terms.
  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  // c(k,n) * 2^13 for n = 0..3; row 0 holds 0.5 so S0/2 rides the multiplier path.
  localparam int COS_Q [8][4] = '{
    '{ 4096,  4096,  4096,  4096},
    '{ 8035,  6811,  4551,  1598},
    '{ 7568,  3135, -3135, -7568},
    '{ 6811, -1598, -8035, -4551},
    '{ 5793, -5793, -5793,  5793},
    '{ 4551, -8035,  1598,  6811},
    '{ 3135, -7568,  7568, -3135},
    '{ 1598, -4551,  6811, -8035}
  };

  // Drop 'shift' fraction bits with round-half-up, then clamp to a w_out-bit signed range.
  function automatic logic signed [31:0] round_sat(
    input logic signed [31:0] value,
    input int                 shift,
    input int                 w_out
  );
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r  = (value + (32'sd1 <<< (shift - 1))) >>> shift;
    hi = (32'sd1 <<< (w_out - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w_out - 1));
    if (r > hi) begin
      return hi;
    end
    if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/idct_pingpong8.sv
`default_nettype none
// ------------------------------------------------------------------
// idct_pingpong8 : 8-slot collect bank plus held bank, swapped at slot 7
// Rev 1.0
// ------------------------------------------------------------------
module idct_pingpong8
  import idct_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  slot_t                  slot,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [7:0][WIDTH-1:0]  held
);

  // Slot 7 is never parked: it goes straight into the held bank at the swap.
  logic [6:0][WIDTH-1:0] r_collect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_collect <= '0;
      held      <= '0;
    end else if (ena) begin
      if (slot == 3'd7) begin
        held <= {wr_data, r_collect};
      end else begin
        r_collect[slot] <= wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/idct_1d.sv
`default_nettype none
// ------------------------------------------------------------------
// idct_1d : streaming 8-point 1-D inverse DCT, one sample per enabled cycle
// Rev 1.0
// ------------------------------------------------------------------
module idct_1d
  import idct_pkg::*;
#(
  parameter int W_IN       = W_IN_DEF,
  parameter int W_OUT      = W_OUT_DEF,
  parameter int CONST_PREC = CONST_PREC_DEF,
  parameter int GUARD      = GUARD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena_in,
  input  logic signed [W_IN-1:0]  s_in,
  output logic signed [W_OUT-1:0] x_out,
  output logic                    valid_out
);

  localparam int W_EO    = W_IN + 4 + GUARD;
  localparam int W_SUM   = W_EO + 1;
  localparam int W_PROD  = W_IN + CONST_PREC;
  localparam int P_SHIFT = CONST_PREC - 1 - GUARD;
  localparam int O_SHIFT = GUARD + 2;
  localparam logic signed [W_PROD-1:0] C_PROD_HALF = W_PROD'(1) << (P_SHIFT - 1);

  slot_t  r_state;
  phase_e w_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
    end else if (ena_in) begin
      r_state <= r_state + 3'd1;
    end
  end

  assign w_phase = phase_e'(r_state[2]);

  // Capture: top bit tags a slot as carrying a real coefficient.
  logic [7:0][W_IN:0] w_in_held;

  idct_pingpong8 #(
    .WIDTH (W_IN + 1)
  ) u_in_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena_in),
    .slot    (r_state),
    .wr_data ({1'b1, s_in}),
    .held    (w_in_held)
  );

  // Compute: lane t multiplies S[2t+phase] by c(2t+phase, state mod 4).
  logic signed [W_EO-1:0] w_term [4];
  logic signed [W_EO-1:0] w_dot;

  for (genvar t = 0; t < 4; t++) begin : g_mult
    logic [2:0]                   w_k;
    logic signed [W_IN-1:0]       w_op;
    logic signed [CONST_PREC-1:0] w_coef;
    logic signed [W_PROD-1:0]     w_prod;

    assign w_k      = {2'(t), w_phase};
    assign w_op     = w_in_held[w_k][W_IN-1:0];
    assign w_coef   = CONST_PREC'(COS_Q[w_k][r_state[1:0]]);
    assign w_prod   = w_op * w_coef;
    assign w_term[t] = W_EO'((w_prod + C_PROD_HALF) >>> P_SHIFT);
  end

  assign w_dot = w_term[0] + w_term[1] + w_term[2] + w_term[3];

  logic [7:0][W_EO-1:0] w_eo_held;
  logic [7:0][0:0]      w_sel_held;

  idct_pingpong8 #(
    .WIDTH (W_EO)
  ) u_eo_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena_in),
    .slot    (r_state),
    .wr_data (w_dot),
    .held    (w_eo_held)
  );

  // Carries the data tag alongside E/O so valid_out tracks the block being emitted.
  idct_pingpong8 #(
    .WIDTH (1)
  ) u_sel_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena_in),
    .slot    (r_state),
    .wr_data (w_in_held[r_state][W_IN]),
    .held    (w_sel_held)
  );

  // Output butterfly: n<4 -> E[n]+O[n], n>=4 -> E[7-n]-O[7-n]; 7-n is ~n in two bits.
  logic [1:0]              w_pair;
  logic signed [W_EO-1:0]  w_e;
  logic signed [W_EO-1:0]  w_o;
  logic signed [W_SUM-1:0] w_sum;

  assign w_pair = (w_phase == PH_ODD) ? ~r_state[1:0] : r_state[1:0];
  assign w_e    = w_eo_held[{1'b0, w_pair}];
  assign w_o    = w_eo_held[{1'b1, w_pair}];
  assign w_sum  = (w_phase == PH_ODD) ? (W_SUM'(w_e) - W_SUM'(w_o))
                                      : (W_SUM'(w_e) + W_SUM'(w_o));

  assign x_out     = W_OUT'(round_sat(32'(w_sum), O_SHIFT, W_OUT));
  assign valid_out = w_sel_held[r_state][0];

endmodule
`default_nettype wire

// File: doc/idct_1d.md
Name: idct_1d

Overview:
- Streaming 8-point 1-D inverse DCT: the decode-side counterpart of the forward dct_1d pipeline.
- Accepts one coefficient per enabled cycle in natural order k=0..7 and emits one reconstructed sample per enabled cycle in order n=0..7.
- Two instances, with a transpose buffer between them, form the 2-D IDCT of the JPEG decode path.
- Internally uses even/odd decomposition with ping-pong buffering, like the forward pipeline.

Parameters:
- W_IN, 15: signed coefficient input width.
- W_OUT, 12: signed sample output width (saturated).
- CONST_PREC, 14: cosine constant width, signed Q1.(CONST_PREC-1).
- GUARD, 3: extra fractional bits carried in the E/O intermediate values.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena_in  in  1  advance enable; the whole pipeline is frozen when low.
- s_in  in  W_IN  signed coefficient S[k], sampled when ena_in=1.
- x_out  out  W_OUT  signed reconstructed sample x[n].
- valid_out  out  1  x_out carries real data (qualified by ena_in).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=0, all buffer registers 0, x_out=0, valid_out=0. Reset takes effect immediately on rst_n falling, including mid-block; the partial block is discarded.
- Transfer function: x[n] = round((E[n]+O[n])/4), with
  - E[n] = S0/2 + S2*c(2,n) + S4*c(4,n) + S6*c(6,n)
  - O[n] = S1*c(1,n) + S3*c(3,n) + S5*c(5,n) + S7*c(7,n)
  - c(k,n) = cos((2n+1)k*pi/16)
  - x[7-n] = round((E[n]-O[n])/4) for n=0..3
  - This inverts the forward scaling S[k] = sum_n x[n]*cos((2n+1)k*pi/16).
- State counter: 3-bit, increments on each ena_in=1 cycle and wraps 7->0. All three ping-pong buffers swap on the enabled cycle where state=7.
- Stage 1, capture: during the enabled cycle at state s, s_in is written to input-buffer slot s.
- Stage 2, compute: during the next block, state s writes one value into the E/O buffer. s=0..3 writes E[s]; s=4..7 writes O[s-4].
  - Each value is a 4-term dot product using four shared multipliers.
  - Constants are muxed by state.
  - Products are rounded to nearest, keeping GUARD fractional bits.
  - Width is W_IN+4+GUARD signed; this must not overflow for any W_IN input.
- Stage 3, output: during the following block, state n drives x_out from the held E/O values.
  - n<4: E[n]+O[n].
  - n>=4: E[7-n]-O[7-n].
  - Then divide by 4 with round-half-up over the GUARD+2 discarded bits, and saturate to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
- Latency: x[n] of block j is presented during the enabled cycle that accepts S[n] of block j+2 (16 enabled cycles).
- Output timing: x_out is combinational from state and registered E/O values only; there is no combinational path from s_in.
- valid_out: 0 from reset until 16 enabled cycles have been accepted, then 1 until the next reset.
- ena_in=0: no register changes and x_out holds its value. Stalls of any length are transparent.
- Back-to-back blocks: sustained at one sample per enabled cycle, with no bubbles.

Decomposition:
- Package idct_pkg:
  - COS_Q[8][4] table: c(k,n) quantized round-to-nearest at CONST_PREC. c(0,n) is stored as 0.5 so S0/2 shares the multiplier path.
  - Default width localparams.
  - The round/saturate function.
- Sub-module idct_pingpong8, parameterized by width:
  - 8-entry collect bank plus 8-entry held bank, swapping on ena_in && state==7.
  - Asynchronous active-low reset.
  - Instantiated three times: input, E/O, output-select.

Test Plan:
- DC block: S=[800,0,0,0,0,0,0,0], ena_in=1 continuously -> valid_out rises after 16 cycles; x_out = 100 for all eight samples.
- Single AC: S1=400, rest 0 -> x_out = 98,83,56,20,-20,-56,-83,-98 (±1 LSB).
- Saturation: S0=16383 -> x_out=2047 x8; S0=-16384 -> x_out=-2048 x8.
- Random back-to-back: 1000 random blocks over the full W_IN range vs a double-precision model -> every sample within ±1 LSB, no gaps between blocks.
- Stall transparency: same 1000 blocks with ena_in low 30% of cycles at random -> identical enabled-cycle output sequence; x_out stable while ena_in=0.
- Reset mid-block: rst_n low during state 5 of the second block, with clk running -> x_out=0 and valid_out=0 without waiting for a clock edge; after release, a DC block of 800 yields 100 x8 with 16-cycle latency and no residue.
